// File: rtl/scroll_pkg.sv
// Shared types and constants for the scrolling 7-segment message controller.
package scroll_pkg;

  localparam int CHAR_W = 5;
  localparam logic [CHAR_W-1:0] BLANK_CHAR = '0;

  typedef enum logic {
    IDLE   = 1'b0,
    SCROLL = 1'b1
  } state_t;

endpackage

// File: rtl/scroll_tick_gen.sv
// Free-running step divider: counts 0..TICK_DIV-1 while enabled, tick at the top count.
module scroll_tick_gen #(
  parameter int TICK_DIV = 25_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= (r_count == LAST) ? '0 : r_count + 1'b1;
    end
  end

  // A stop or clear in the top-count cycle still lets that tick out.
  assign tick = enable && (r_count == LAST);

endmodule

// File: rtl/scroll_ctrl.sv
// Loads a message into an external character buffer and scrolls it across a
// window of 7-segment digits, one digit per tick, newest character at digit 0.
module scroll_ctrl
  import scroll_pkg::*;
#(
  parameter int BUFFER_SIZE = 16,
  parameter int NUM_DIGITS  = 6,
  parameter int TICK_DIV    = 25_000_000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cmd_clear,
  input  logic                          wr_valid,
  input  logic [CHAR_W-1:0]             wr_data,
  output logic                          wr_ready,
  input  logic                          start,
  input  logic                          stop,
  output logic                          buffer_clear,
  output logic                          buffer_write,
  output logic [CHAR_W-1:0]             buffer_data,
  output logic                          next_char,
  input  logic [CHAR_W-1:0]             hex_char,
  output logic [NUM_DIGITS*CHAR_W-1:0]  display,
  output logic                          busy,
  output logic [$clog2(BUFFER_SIZE):0]  msg_len
);

  localparam int LEN_W  = $clog2(BUFFER_SIZE) + 1;
  localparam int DISP_W = NUM_DIGITS * CHAR_W;
  localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(BUFFER_SIZE);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_wr_ready;
  logic                w_hs;
  logic                w_tick;
  logic                w_cnt_clear;
  logic                r_shift_pend;
  logic                r_buffer_write;
  logic                r_buffer_clear;
  logic [CHAR_W-1:0]   r_buffer_data;
  logic [LEN_W-1:0]    r_msg_len;
  logic [DISP_W-1:0]   r_display;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Host writes are only ever accepted in IDLE, so start and a write can
  // coincide: the write lands and the same edge enters SCROLL.
  always_comb begin
    w_state_nxt = r_state;
    w_wr_ready  = (r_state == IDLE) && (r_msg_len < FULL_LEN) && !cmd_clear;
    w_hs        = wr_valid && w_wr_ready;
    w_cnt_clear = (r_state != SCROLL) || stop || cmd_clear;
    if (cmd_clear) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (start && ((r_msg_len != '0) || w_hs)) w_state_nxt = SCROLL;
        SCROLL:  if (stop) w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  scroll_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (r_state == SCROLL),
    .clear  (w_cnt_clear),
    .tick   (w_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buffer_write <= 1'b0;
      r_buffer_data  <= '0;
      r_buffer_clear <= 1'b0;
      r_shift_pend   <= 1'b0;
      r_msg_len      <= '0;
      r_display      <= '0;
    end else begin
      r_buffer_write <= w_hs;
      if (w_hs) r_buffer_data <= wr_data;
      r_buffer_clear <= cmd_clear;
      // hex_char arrives one cycle after next_char, so the shift is deferred.
      r_shift_pend   <= w_tick && !cmd_clear;
      if (cmd_clear) begin
        r_msg_len <= '0;
        r_display <= {NUM_DIGITS{BLANK_CHAR}};
      end else begin
        if (w_hs) r_msg_len <= r_msg_len + 1'b1;
        if (r_shift_pend) r_display <= {r_display[DISP_W-CHAR_W-1:0], hex_char};
      end
    end
  end

  assign wr_ready     = w_wr_ready;
  assign buffer_clear = r_buffer_clear;
  assign buffer_write = r_buffer_write;
  assign buffer_data  = r_buffer_data;
  assign next_char    = w_tick;
  assign display      = r_display;
  assign busy         = (r_state == SCROLL);
  assign msg_len      = r_msg_len;

endmodule

// File: tb/tb_scroll_ctrl.sv
// Bench for scroll_ctrl with an attached circular character buffer model.
module tb_scroll_ctrl;

  localparam int TD = 4;
  localparam int ND = 6;
  localparam int BS = 16;

  logic            clk, rst_n, cmd_clear, wr_valid, wr_ready, start, stop;
  logic            buffer_clear, buffer_write, next_char, busy;
  logic [4:0]      wr_data, buffer_data, hex_char;
  logic [ND*5-1:0] display;
  logic [4:0]      msg_len;

  scroll_ctrl #(.BUFFER_SIZE(BS), .NUM_DIGITS(ND), .TICK_DIV(TD)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_clear(cmd_clear), .wr_valid(wr_valid),
    .wr_data(wr_data), .wr_ready(wr_ready), .start(start), .stop(stop),
    .buffer_clear(buffer_clear), .buffer_write(buffer_write),
    .buffer_data(buffer_data), .next_char(next_char), .hex_char(hex_char),
    .display(display), .busy(busy), .msg_len(msg_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_asrt = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Circular character buffer: reads wrap over the characters written so far.
  logic [4:0]  mem [BS];
  int unsigned b_wp, b_rp, b_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_wp <= 0; b_rp <= 0; b_cnt <= 0; hex_char <= '0;
    end else if (buffer_clear) begin
      b_wp <= 0; b_rp <= 0; b_cnt <= 0;
    end else begin
      if (buffer_write && b_wp < BS) begin
        mem[b_wp] <= buffer_data; b_wp <= b_wp + 1; b_cnt <= b_cnt + 1;
      end
      if (next_char) begin
        hex_char <= mem[b_rp];
        b_rp <= (b_rp + 1 >= b_cnt) ? 0 : b_rp + 1;
      end
    end
  end

  int unsigned nc_q[$];
  always @(negedge clk) begin
    if (rst_n && next_char) begin
      nc_q.push_back(cyc);
      chk("nc_only_when_busy", busy, 1'b1);
    end
  end

  // Reference: after k steps, digit d shows message character (k-1-d) mod len.
  logic [4:0] msg_q[$];
  int unsigned run_start;
  int steps;

  function automatic logic [ND*5-1:0] exp_disp(input int k);
    logic [ND*5-1:0] r = '0;
    for (int d = 0; d < ND; d++)
      if (k - 1 - d >= 0) r[d*5 +: 5] = msg_q[(k - 1 - d) % msg_q.size()];
    return r;
  endfunction

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic wait_nc;
    int n = 0;
    while (next_char !== 1'b1 && n < 4 * TD) begin tick; n++; end
    chk("next_char_wait", next_char, 1'b1);
  endtask

  task automatic scroll_step;
    wait_nc;
    chk("next_char_time", cyc, run_start + TD - 1 + TD * steps);
    tick; tick;
    steps++;
    chk("display_step", display, exp_disp(steps));
  endtask

  task automatic do_start;
    start = 1'b1; tick; start = 1'b0;
    run_start = cyc; steps = 0;
    chk("busy_after_start", busy, 1'b1);
  endtask

  initial begin
    int unsigned n_nc, len;
    logic [ND*5-1:0] held;
    logic co;
    rst_n = 1'b0; cmd_clear = 0; wr_valid = 0; wr_data = '0; start = 0; stop = 0;
    #2;
    chk("rst_busy", busy, 1'b0);
    chk("rst_msg_len", msg_len, 0);
    chk("rst_display", display, 0);
    chk("rst_next_char", next_char, 1'b0);
    chk("rst_buffer_write", buffer_write, 1'b0);
    chk("rst_buffer_clear", buffer_clear, 1'b0);
    tick; tick;

    // Release between edges; first write accepted on the very next edge.
    #2 rst_n = 1'b1;
    msg_q.delete(); msg_q.push_back(5'd3); msg_q.push_back(5'd7); msg_q.push_back(5'd9);
    wr_valid = 1'b1; wr_data = 5'd3; tick;
    chk("first_hs_len", msg_len, 1);
    chk("first_hs_write", buffer_write, 1'b1);
    chk("first_hs_data", buffer_data, 5'd3);
    wr_data = 5'd7; tick;
    wr_data = 5'd9; tick;
    wr_valid = 1'b0;
    chk("len_3", msg_len, 3);
    do_start;
    repeat (4) scroll_step;
    chk("display_0_0_3_7_9_3", display, {5'd0, 5'd0, 5'd3, 5'd7, 5'd9, 5'd3});

    // stop coincident with a next_char pulse
    wait_nc;
    stop = 1'b1; tick; stop = 1'b0;
    chk("stop_idle", busy, 1'b0);
    n_nc = nc_q.size();
    tick; steps++;
    chk("stop_shift_done", display, exp_disp(steps));
    repeat (3 * TD) tick;
    chk("stop_no_more_nc", nc_q.size(), n_nc);
    chk("stop_display_holds", display, exp_disp(steps));

    // cmd_clear wins over a coincident start
    cmd_clear = 1'b1; start = 1'b1; #1;
    chk("clear_blocks_ready", wr_ready, 1'b0);
    tick; cmd_clear = 1'b0; start = 1'b0;
    chk("clear_pulse", buffer_clear, 1'b1);
    chk("clear_idle", busy, 1'b0);
    chk("clear_len", msg_len, 0);
    chk("clear_display", display, 0);
    tick;
    chk("clear_pulse_one_cycle", buffer_clear, 1'b0);

    // start with an empty message is ignored
    n_nc = nc_q.size();
    start = 1'b1; tick; start = 1'b0;
    chk("empty_start_idle", busy, 1'b0);
    repeat (2 * TD) tick;
    chk("empty_start_no_nc", nc_q.size(), n_nc);

    // 17 back-to-back writes: 16 accepted, the 17th held
    wr_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      wr_data = 5'(i + 1); #1;
      chk("fill_ready", wr_ready, (i < BS) ? 1'b1 : 1'b0);
      tick;
      chk("fill_len", msg_len, (i < BS) ? i + 1 : BS);
      chk("fill_write", buffer_write, (i < BS) ? 1'b1 : 1'b0);
    end
    repeat (3) tick;
    chk("full_ready_low", wr_ready, 1'b0);
    chk("full_len", msg_len, BS);
    chk("full_buffer_count", b_cnt, BS);
    wr_valid = 1'b0;

    // Random messages, gapped writes, random scroll lengths
    for (int r = 0; r < 6; r++) begin
      cmd_clear = 1'b1; tick; cmd_clear = 1'b0; tick;
      msg_q.delete();
      len = $urandom_range(1, BS);
      for (int i = 0; i < int'(len); i++) msg_q.push_back(5'($urandom_range(0, 31)));
      co = r[0];
      for (int i = 0; i < int'(len); i++) begin
        repeat ($urandom_range(0, 2)) tick;
        wr_valid = 1'b1; wr_data = msg_q[i];
        if (co && i == int'(len) - 1) start = 1'b1;
        #1 chk("rnd_ready", wr_ready, 1'b1);
        tick;
        wr_valid = 1'b0;
        chk("rnd_data", buffer_data, msg_q[i]);
        chk("rnd_len", msg_len, i + 1);
      end
      if (co) begin
        start = 1'b0; run_start = cyc; steps = 0;
        chk("rnd_start_with_write", busy, 1'b1);
      end else begin
        do_start;
      end
      repeat ($urandom_range(1, 10)) scroll_step;
      stop = 1'b1; tick; stop = 1'b0;
      chk("rnd_stop", busy, 1'b0);
      repeat (2 * TD) tick;
      chk("rnd_hold", display, exp_disp(steps));
    end

    // Asynchronous reset mid-scroll
    cmd_clear = 1'b1; tick; cmd_clear = 1'b0;
    msg_q.delete(); msg_q.push_back(5'd1); msg_q.push_back(5'd2);
    for (int i = 0; i < 2; i++) begin
      wr_valid = 1'b1; wr_data = msg_q[i]; tick;
    end
    wr_valid = 1'b0;
    do_start;
    scroll_step; scroll_step;
    wait_nc;
    held = display;
    chk("pre_reset_display", held, exp_disp(steps));
    #2 rst_n = 1'b0; #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_display", display, 0);
    chk("arst_msg_len", msg_len, 0);
    chk("arst_next_char", next_char, 1'b0);
    chk("arst_buffer_write", buffer_write, 1'b0);
    chk("arst_buffer_data", buffer_data, 0);
    chk("arst_buffer_clear", buffer_clear, 1'b0);
    tick;
    #2 rst_n = 1'b1;
    msg_q.delete(); msg_q.push_back(5'd5);
    wr_valid = 1'b1; wr_data = 5'd5;
    start = 1'b1; tick; start = 1'b0; wr_valid = 1'b0;
    run_start = cyc; steps = 0;
    chk("post_reset_busy", busy, 1'b1);
    scroll_step;
    chk("post_reset_shows_5", display, {5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd5});

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule

// File: doc/scroll_ctrl.md
SCROLL_CTRL -- requirements
Module: scroll_ctrl

Interface
REQ-001 SHALL have parameter BUFFER_SIZE, default 16: character capacity of the attached scrolling buffer.
REQ-002 SHALL have parameter NUM_DIGITS, default 6: number of 7-segment character positions in the display window.
REQ-003 SHALL have parameter TICK_DIV, default 25_000_000: clock cycles per scroll step, minimum 2.
REQ-004 SHALL have one clock and an asynchronous, active-low reset; ports are listed below.
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_clear  in  1  one-cycle pulse: flush the message
- wr_valid  in  1  host character valid
- wr_data  in  5  host character code
- wr_ready  out  1  controller accepts a character
- start  in  1  one-cycle pulse: begin scrolling
- stop  in  1  one-cycle pulse: halt scrolling
- buffer_clear  out  1  to buffer: clear pointers
- buffer_write  out  1  to buffer: write strobe
- buffer_data  out  5  to buffer: write data
- next_char  out  1  to buffer: read strobe
- hex_char  in  5  from buffer: character, valid the cycle after next_char
- display  out  NUM_DIGITS*5  window; digit 0 in bits [4:0] is rightmost/newest
- busy  out  1  high while in SCROLL
- msg_len  out  $clog2(BUFFER_SIZE)+1  characters loaded

Function
REQ-005 SHALL implement FSM states IDLE and SCROLL; reset state is IDLE.
REQ-006 wr_ready SHALL be combinational: (state==IDLE) && (msg_len<BUFFER_SIZE) && !cmd_clear.
REQ-007 A handshake (wr_valid && wr_ready) SHALL drive buffer_write=1 and buffer_data=wr_data on the next cycle, and increment msg_len by 1; buffer_write SHALL otherwise be 0.
REQ-008 msg_len SHALL never exceed BUFFER_SIZE; while full, wr_ready=0 and host data is held, not dropped.
REQ-009 IDLE->SCROLL on start when msg_len>0 or a handshake occurs in the same cycle; otherwise start SHALL be ignored.
REQ-010 In SCROLL a tick counter SHALL count 0..TICK_DIV-1, wrap, and pulse next_char for exactly one cycle at count TICK_DIV-1; the counter SHALL reset to 0 on entering SCROLL.
REQ-011 The cycle after any next_char pulse, display SHALL shift left one digit: digit k <= digit k-1, digit 0 <= hex_char.
REQ-012 SCROLL->IDLE on stop; the counter clears; display holds; a shift pending from a next_char in the stop cycle still completes.
REQ-013 cmd_clear SHALL, next cycle: pulse buffer_clear for one cycle, msg_len<=0, display<=0, state<=IDLE; any pending shift is discarded.
REQ-014 Priority when coincident: cmd_clear > stop > start > host write.
REQ-015 busy SHALL equal (state==SCROLL).
REQ-016 next_char SHALL be 0 in IDLE; no buffer_write SHALL occur in SCROLL.

Reset
REQ-017 Asserting rst_n low SHALL immediately force state=IDLE, counter=0, msg_len=0, display=0, buffer_write=0, buffer_data=0, buffer_clear=0, next_char=0, mid-scroll included.
REQ-018 After rst_n deasserts, the first host handshake SHALL be accepted on the first rising clk edge.

Structure
REQ-019 Package scroll_pkg SHALL hold the state enum (IDLE, SCROLL), CHAR_W=5 and the blank character code 0.
REQ-020 The tick counter SHALL be the sub-module scroll_tick_gen (inputs enable and clear, output tick), parameterised by TICK_DIV.

Verification (TICK_DIV=4, NUM_DIGITS=6, BUFFER_SIZE=16, buffer model attached)
REQ-021 Write 3,7,9, then start -> next_char every 4 cycles; display digit 0 sequence is 3,7,9,3; after 4 steps display = {0,0,3,7,9,3}.
REQ-022 Write 17 characters back-to-back -> 16 accepted, wr_ready=0 from the cycle msg_len=16, 17th held with wr_valid high.
REQ-023 start with msg_len=0 and no write -> stays IDLE, busy=0, no next_char.
REQ-024 stop in the same cycle as a next_char pulse -> IDLE next cycle, shift still occurs, no further next_char; cmd_clear plus start together -> buffer_clear pulse, IDLE, msg_len=0.
REQ-025 rst_n low mid-SCROLL between clock edges -> all outputs 0 immediately, without waiting for a clk edge; after release, a write of 5 plus start scrolls 5.
